// File: rtl/img_row_loader_pkg.sv
// Shared geometry constants and loader FSM state encoding for the image row loader.
package sift_pkg;

    localparam int IMG_W    = 640;
    localparam int IMG_H    = 480;
    localparam int PIX_W    = 8;
    localparam int ROW_BITS = IMG_W * PIX_W;
    localparam int ADDR_W   = 9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } ld_state_e;

endpackage

// File: rtl/img_row_loader_if.sv
// Pixel-stream handshake and row-memory write bundle for img_row_loader.
// The frame_sum signal exists only when IMG_ROW_LOADER_SUM_EN is defined.
interface img_row_loader_if
    import sift_pkg::*;
#(
    parameter int IMG_W = sift_pkg::IMG_W,
    parameter int PIX_W = sift_pkg::PIX_W
);

    logic                     load_start;
    logic                     pix_valid;
    logic [PIX_W-1:0]         pix_data;
    logic                     pix_ready;
    logic                     img_we;
    logic [ADDR_W-1:0]        img_addr;
    logic [IMG_W*PIX_W-1:0]   img_din;
    logic                     busy;
    logic                     done;
`ifdef IMG_ROW_LOADER_SUM_EN
    logic [31:0]              frame_sum;

    modport master (output load_start, pix_valid, pix_data,
                    input  pix_ready, img_we, img_addr, img_din, busy, done, frame_sum);
    modport slave  (input  load_start, pix_valid, pix_data,
                    output pix_ready, img_we, img_addr, img_din, busy, done, frame_sum);
`else
    modport master (output load_start, pix_valid, pix_data,
                    input  pix_ready, img_we, img_addr, img_din, busy, done);
    modport slave  (input  load_start, pix_valid, pix_data,
                    output pix_ready, img_we, img_addr, img_din, busy, done);
`endif

endinterface

// File: rtl/img_row_loader_row_packer.sv
// Row assembly: shifts accepted pixels into a row-wide register and tracks the column.
module row_packer
    import sift_pkg::*;
#(
    parameter int IMG_W = sift_pkg::IMG_W,
    parameter int PIX_W = sift_pkg::PIX_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr_i,
    input  logic                   xfer_i,
    input  logic [PIX_W-1:0]       pix_i,
    output logic [IMG_W*PIX_W-1:0] row_o,
    output logic                   last_o
);

    localparam int RB    = IMG_W * PIX_W;
    localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;

    logic [RB-1:0]    shreg_q, shreg_d;
    logic [COL_W-1:0] col_q, col_d;

    assign last_o = (col_q == COL_W'(IMG_W - 1));
    assign row_o  = shreg_q;

    // Shifting left means the first pixel of a row ends up in the MSBs after IMG_W transfers.
    always_comb begin
        shreg_d = shreg_q;
        col_d   = col_q;
        if (clr_i) begin
            col_d = '0;
        end else if (xfer_i) begin
            shreg_d = {shreg_q[RB-PIX_W-1:0], pix_i};
            col_d   = last_o ? '0 : col_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
            col_q   <= '0;
        end else begin
            shreg_q <= shreg_d;
            col_q   <= col_d;
        end
    end

endmodule

// File: rtl/img_row_loader.sv
// Frame loader: packs a raster pixel stream into rows and writes one row per WRITE cycle.
// Optional frame_sum accumulator is built when IMG_ROW_LOADER_SUM_EN is defined.
module img_row_loader
    import sift_pkg::*;
#(
    parameter int IMG_W = sift_pkg::IMG_W,
    parameter int IMG_H = sift_pkg::IMG_H,
    parameter int PIX_W = sift_pkg::PIX_W
) (
    input  logic           clk,
    input  logic           rst,
    img_row_loader_if.slave bus
);

    localparam int RB = IMG_W * PIX_W;

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] row_q, row_d;
    logic              start;
    logic              xfer;
    logic              last;
    logic [RB-1:0]     row_bits;

    assign start = (state_q == ST_IDLE) && bus.load_start;
    assign xfer  = (state_q == ST_FILL) && bus.pix_valid;

    row_packer #(
        .IMG_W (IMG_W),
        .PIX_W (PIX_W)
    ) u_packer (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (start),
        .xfer_i (xfer),
        .pix_i  (bus.pix_data),
        .row_o  (row_bits),
        .last_o (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
        end
    end

    // Address and data are forced to zero outside WRITE so they only move together with img_we.
    always_comb begin
        state_d       = state_q;
        row_d         = row_q;
        bus.pix_ready = 1'b0;
        bus.img_we    = 1'b0;
        bus.img_addr  = '0;
        bus.img_din   = '0;
        bus.busy      = 1'b0;
        bus.done      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_FILL;
                    row_d   = '0;
                end
            end
            ST_FILL: begin
                bus.pix_ready = 1'b1;
                bus.busy      = 1'b1;
                if (xfer && last) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                bus.img_we   = 1'b1;
                bus.img_addr = row_q;
                bus.img_din  = row_bits;
                bus.busy     = 1'b1;
                if (row_q == ADDR_W'(IMG_H - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    row_d   = row_q + 1'b1;
                    state_d = ST_FILL;
                end
            end
            ST_DONE: begin
                bus.done = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef IMG_ROW_LOADER_SUM_EN
    logic [31:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start)     sum_d = '0;
        else if (xfer) sum_d = sum_q + 32'(bus.pix_data);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sum_q <= '0;
        else     sum_q <= sum_d;
    end

    assign bus.frame_sum = sum_q;
`endif

endmodule

// File: tb/tb_img_row_loader.sv
// Self-checking bench for img_row_loader on a reduced 16x8 geometry; frame_sum checks need IMG_ROW_LOADER_SUM_EN.
module tb_img_row_loader;

    localparam int W         = 16;
    localparam int H         = 8;
    localparam int P         = 8;
    localparam int RB        = W * P;
    localparam int TOTAL     = W * H;
    localparam int FRAME_CYC = H * (W + 1) + 1;
    localparam int BUDGET    = 4 * TOTAL + 100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    img_row_loader_if #(.IMG_W(W), .PIX_W(P)) bus();

    img_row_loader #(.IMG_W(W), .IMG_H(H), .PIX_W(P)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [P-1:0]  pix [TOTAL];
    logic [8:0]    wr_addr [$];
    logic [RB-1:0] wr_data [$];
    int            cyc      = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            viol     = 0;
    int            ls_cyc   = 0;
    logic          prev_we  = 1'b0;
    logic [8:0]    prev_addr = '0;
    logic [RB-1:0] prev_din  = '0;
    logic [31:0]   sum_at_done = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records memory writes and done pulses, counts handshake/stability violations.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.img_we) begin
                wr_addr.push_back(bus.img_addr);
                wr_data.push_back(bus.img_din);
            end
            if (bus.done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
`ifdef IMG_ROW_LOADER_SUM_EN
                sum_at_done <= bus.frame_sum;
`endif
            end
            if ((bus.pix_ready && bus.img_we) || (bus.busy && !bus.pix_ready && !bus.img_we) ||
                (bus.img_we && !bus.busy) || (bus.done && bus.busy) ||
                (!bus.img_we && !prev_we && (bus.img_addr != prev_addr || bus.img_din != prev_din)))
                viol <= viol + 1;
        end
        prev_we   <= bus.img_we;
        prev_addr <= bus.img_addr;
        prev_din  <= bus.img_din;
    end

    task automatic chk(input string tag, input logic [RB-1:0] got, input logic [RB-1:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chki(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [RB-1:0] exp_row(input int r);
        logic [RB-1:0] w;
        w = '0;
        for (int c = 0; c < W; c++) w[(W-1-c)*P +: P] = pix[r*W+c];
        return w;
    endfunction

    function automatic int model_sum();
        int s;
        s = 0;
        for (int i = 0; i < TOTAL; i++) s += int'(pix[i]);
        return s;
    endfunction

    task automatic chk_zero(input string tag);
        chki({tag, "_ready"}, int'(bus.pix_ready), 0);
        chki({tag, "_we"},    int'(bus.img_we), 0);
        chki({tag, "_addr"},  int'(bus.img_addr), 0);
        chk ({tag, "_din"},   bus.img_din, '0);
        chki({tag, "_busy"},  int'(bus.busy), 0);
        chki({tag, "_done"},  int'(bus.done), 0);
    endtask

    task automatic clear_mon();
        wr_addr.delete();
        wr_data.delete();
        done_cnt = 0;
        viol     = 0;
    endtask

    // mode 0: valid always, 1: valid every other cycle, 2: random bubbles.
    task automatic run_frame(input int mode, input int stop_at, input int ls2_at);
        int idx;
        int n;
        idx = 0;
        n   = 0;
        while (idx < stop_at && n < BUDGET) begin
            @(posedge clk); #1;
            bus.load_start = (n == 0) || (idx == ls2_at);
            case (mode)
                0:       bus.pix_valid = 1'b1;
                1:       bus.pix_valid = (n % 2 == 0);
                default: bus.pix_valid = ($urandom_range(0, 3) != 0);
            endcase
            bus.pix_data = pix[idx];
            @(negedge clk);
            if (n == 0) ls_cyc = cyc;
            if (bus.pix_valid && bus.pix_ready) idx++;
            n++;
        end
        chki("feed_progress", idx, stop_at);
    endtask

    task automatic finish_frame();
        @(posedge clk); #1;
        bus.load_start = 1'b0;
        bus.pix_valid  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_frame(input string tag);
        chki({tag, "_writes"}, wr_addr.size(), H);
        for (int r = 0; r < wr_addr.size() && r < H; r++) begin
            chki($sformatf("%s_addr%0d", tag, r), int'(wr_addr[r]), r);
            chk ($sformatf("%s_row%0d", tag, r), wr_data[r], exp_row(r));
        end
        chki({tag, "_done_pulses"}, done_cnt, 1);
        chki({tag, "_violations"}, viol, 0);
`ifdef IMG_ROW_LOADER_SUM_EN
        chki({tag, "_sum"}, int'(sum_at_done), model_sum());
`endif
    endtask

    task automatic fill_random();
        for (int i = 0; i < TOTAL; i++) pix[i] = P'($urandom);
    endtask

    initial begin
        rst            = 1'b1;
        bus.load_start = 1'b0;
        bus.pix_valid  = 1'b0;
        bus.pix_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        @(posedge clk); #1;
        rst = 1'b0;

        // Pixels offered while idle must not start anything.
        clear_mon();
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            bus.pix_valid = 1'($urandom);
            bus.pix_data  = P'($urandom);
        end
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chki("idle_writes", wr_addr.size(), 0);
        chki("idle_busy", int'(bus.busy), 0);
        chki("idle_violations", viol, 0);

        // Ramp frame, continuous valid.
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) pix[r*W+c] = P'((r + c) % 256);
        clear_mon();
        run_frame(0, TOTAL, -1);
        finish_frame();
        check_frame("ramp");
        chki("ramp_latency", done_cyc - ls_cyc, FRAME_CYC);
        chk("ramp_row0_msb", RB'(wr_data[0][RB-1 -: P]), RB'(0));
        chk("ramp_row0_lsb", RB'(wr_data[0][P-1:0]), RB'(W - 1));

        // Valid toggling, plus a load_start retry in the middle of row 3.
        fill_random();
        clear_mon();
        run_frame(1, TOTAL, 3 * W + 2);
        finish_frame();
        check_frame("toggle");

        // Random bubbles.
        fill_random();
        clear_mon();
        run_frame(2, TOTAL, -1);
        finish_frame();
        check_frame("bubble");

        // Abort at row 5, column 9.
        fill_random();
        clear_mon();
        run_frame(2, 5 * W + 9, -1);
        #1;
        rst = 1'b1;
        #1;
        chk_zero("abort");
        chki("abort_writes_before", wr_addr.size(), 5);
        repeat (2) @(posedge clk);
        #1;
        rst            = 1'b0;
        bus.load_start = 1'b0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            bus.pix_valid = 1'b1;
            bus.pix_data  = P'($urandom);
        end
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chki("abort_writes_after", wr_addr.size(), 5);
        chki("abort_busy", int'(bus.busy), 0);

        // Fresh frame after the abort restarts from address 0.
        fill_random();
        clear_mon();
        run_frame(0, TOTAL, -1);
        finish_frame();
        check_frame("restart");

`ifdef IMG_ROW_LOADER_SUM_EN
        for (int i = 0; i < TOTAL; i++) pix[i] = '1;
        clear_mon();
        run_frame(0, TOTAL, -1);
        finish_frame();
        check_frame("allff");
        chki("allff_sum_const", int'(sum_at_done), TOTAL * 255);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
